axi4_wr_traffic_gen: RTL and testbench

AXI4_WR_TRAFFIC_GEN -- requirements
Module: axi4_wr_traffic_gen

---
 rtl/axi4_wr_traffic_gen.sv | 191 +++++++++++++++++++
 tb/tb_axi4_wr_traffic_gen.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_wr_traffic_gen.sv
// AXI4 write traffic generator: issues num_bursts INCR bursts of 64-byte beats
// from base_addr, tracks outstanding responses and reports run status.
module axi4_wr_traffic_gen #(
  parameter logic [15:0] AXI_ID          = 16'h0,
  parameter int          MAX_OUTSTANDING = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [63:0]  base_addr,
  input  logic [15:0]  num_bursts,
  input  logic [7:0]   burst_len,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [31:0]  cycles,
  output logic [15:0]  awid,
  output logic [63:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic         awvalid,
  input  logic         awready,
  output logic [511:0] wdata,
  output logic [63:0]  wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [15:0]  bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t         state_r, state_s;
  logic [15:0]    nb_r, aw_cnt_r, b_cnt_r, w_burst_r;
  logic [7:0]     len_r, w_beat_r;
  logic [63:0]    aw_ptr_r, w_ptr_r, awaddr_r;
  logic [511:0]   wdata_r;
  logic           awvalid_r, wvalid_r, wlast_r, bready_r, busy_r, done_r, err_r;
  logic [31:0]    cycles_r;

  logic           start_acc_s, aw_hs_s, w_hs_s, b_hs_s, aw_ok_s, w_ok_s;
  logic [15:0]    aw_cnt_n_s, b_cnt_n_s, w_burst_n_s, outstanding_s;
  logic [7:0]     w_beat_n_s;
  logic [8:0]     beats_s;
  logic [63:0]    stride_s, aw_ptr_n_s, w_ptr_n_s;
  logic           unused_s;

  function automatic logic [511:0] lane_fill(input logic [31:0] a);
    lane_fill = {16{a}};
  endfunction

  assign unused_s = ^bid;

  assign start_acc_s   = (state_r == IDLE) && start;
  assign aw_hs_s       = awvalid_r && awready;
  assign w_hs_s        = wvalid_r && wready;
  assign b_hs_s        = bvalid && bready_r;
  assign beats_s       = {1'b0, len_r} + 9'd1;
  assign stride_s      = {49'd0, beats_s, 6'd0};
  assign aw_cnt_n_s    = aw_cnt_r + {15'd0, aw_hs_s};
  assign b_cnt_n_s     = b_cnt_r + {15'd0, b_hs_s};
  assign aw_ptr_n_s    = aw_hs_s ? (aw_ptr_r + stride_s) : aw_ptr_r;
  assign w_ptr_n_s     = w_hs_s ? (w_ptr_r + 64'd64) : w_ptr_r;
  assign w_beat_n_s    = w_hs_s ? (wlast_r ? 8'd0 : (w_beat_r + 8'd1)) : w_beat_r;
  assign w_burst_n_s   = w_burst_r + {15'd0, (w_hs_s && wlast_r)};
  // Decisions look at post-handshake counts so a same-cycle B frees a slot at once.
  assign outstanding_s = aw_cnt_n_s - b_cnt_n_s;
  assign aw_ok_s       = (state_r == RUN) && (aw_cnt_n_s < nb_r) &&
                         (outstanding_s < 16'(MAX_OUTSTANDING));
  assign w_ok_s        = (state_r == RUN) && (w_burst_n_s < aw_cnt_n_s);

  assign awid    = AXI_ID;
  assign awaddr  = awaddr_r;
  assign awlen   = len_r;
  assign awsize  = 3'b110;
  assign awvalid = awvalid_r;
  assign wdata   = wdata_r;
  assign wstrb   = {64{1'b1}};
  assign wlast   = wlast_r;
  assign wvalid  = wvalid_r;
  assign bready  = bready_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign err     = err_r;
  assign cycles  = cycles_r;

  // Run state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (start) state_s = RUN; else state_s = IDLE;
      RUN:     if (b_cnt_n_s == nb_r) state_s = DONE; else state_s = RUN;
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Run parameters and burst/beat/response progress counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      nb_r      <= 16'd0;
      len_r     <= 8'd0;
      aw_cnt_r  <= 16'd0;
      b_cnt_r   <= 16'd0;
      w_burst_r <= 16'd0;
      w_beat_r  <= 8'd0;
      aw_ptr_r  <= 64'd0;
      w_ptr_r   <= 64'd0;
    end else if (start_acc_s) begin
      nb_r      <= num_bursts;
      len_r     <= burst_len;
      aw_cnt_r  <= 16'd0;
      b_cnt_r   <= 16'd0;
      w_burst_r <= 16'd0;
      w_beat_r  <= 8'd0;
      aw_ptr_r  <= base_addr;
      w_ptr_r   <= base_addr;
    end else begin
      aw_cnt_r  <= aw_cnt_n_s;
      b_cnt_r   <= b_cnt_n_s;
      w_burst_r <= w_burst_n_s;
      w_beat_r  <= w_beat_n_s;
      aw_ptr_r  <= aw_ptr_n_s;
      w_ptr_r   <= w_ptr_n_s;
    end
  end

  // Write-address channel: hold while stalled, otherwise present the next burst.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      awvalid_r <= 1'b0;
      awaddr_r  <= 64'd0;
    end else if (awvalid_r && !awready) begin
      awvalid_r <= awvalid_r;
      awaddr_r  <= awaddr_r;
    end else begin
      awvalid_r <= aw_ok_s;
      awaddr_r  <= aw_ptr_n_s;
    end
  end

  // Write-data channel: beats are contiguous, so the beat address is a running pointer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wvalid_r <= 1'b0;
      wlast_r  <= 1'b0;
      wdata_r  <= 512'd0;
    end else if (wvalid_r && !wready) begin
      wvalid_r <= wvalid_r;
      wlast_r  <= wlast_r;
      wdata_r  <= wdata_r;
    end else begin
      wvalid_r <= w_ok_s;
      wlast_r  <= w_ok_s && (w_beat_n_s == len_r);
      wdata_r  <= lane_fill(w_ptr_n_s[31:0]);
    end
  end

  // Status outputs, response acceptance, sticky error and saturating run timer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      bready_r <= 1'b0;
      err_r    <= 1'b0;
      cycles_r <= 32'd0;
    end else begin
      busy_r   <= (state_s != IDLE);
      done_r   <= (state_s == DONE);
      bready_r <= (state_s == RUN);
      if (start_acc_s) begin
        err_r    <= 1'b0;
        cycles_r <= 32'd0;
      end else begin
        err_r <= err_r || (b_hs_s && (bresp != 2'b00));
        if ((state_r == RUN) && (cycles_r != 32'hFFFF_FFFF)) cycles_r <= cycles_r + 32'd1;
        else                                                 cycles_r <= cycles_r;
      end
    end
  end

endmodule

// File: tb/tb_axi4_wr_traffic_gen.sv
// Directed-plus-random bench for axi4_wr_traffic_gen; a behavioural slave and
// address/data model live inside the single stimulus process.
module tb_axi4_wr_traffic_gen;

  localparam int          MAXO  = 4;
  localparam logic [15:0] TB_ID = 16'hA5C3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n, start;
  logic [63:0]  base_addr;
  logic [15:0]  num_bursts;
  logic [7:0]   burst_len;
  logic         busy, done, err;
  logic [31:0]  cycles;
  logic [15:0]  awid;
  logic [63:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic         awvalid, awready;
  logic [511:0] wdata;
  logic [63:0]  wstrb;
  logic         wlast, wvalid, wready;
  logic [15:0]  bid;
  logic [1:0]   bresp;
  logic         bvalid, bready;

  axi4_wr_traffic_gen #(.AXI_ID(TB_ID), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .num_bursts(num_bursts), .burst_len(burst_len), .busy(busy), .done(done),
    .err(err), .cycles(cycles), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awvalid(awvalid), .awready(awready), .wdata(wdata),
    .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready), .bid(bid),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  int total = 0;
  int bad = 0;

  logic [63:0]  m_base;
  int           m_nb, m_beats, err_burst, ncyc, run_start;
  bit           rdy_rand, b_hold;
  int           aw_done, w_beats, b_done, awv_seen;
  int           bq[$];
  bit           b_fire, aw_stall, w_stall;
  logic [63:0]  aw_prev;
  logic [511:0] w_prev_data;
  logic         w_prev_last;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    aw_done = 0; w_beats = 0; b_done = 0; awv_seen = 0;
    bq.delete();
    b_fire = 1'b0; bvalid = 1'b0; aw_stall = 1'b0; w_stall = 1'b0;
  endtask

  // One clock of slave behaviour: checks stalls, drives readies/B, predicts handshakes.
  task automatic tick();
    logic [63:0] ea;
    int k;
    @(negedge clk);
    ncyc++;
    if (aw_stall && rst_n) begin
      chk1("aw_hold_valid", awvalid, 1'b1);
      chk("aw_hold_addr", awaddr, aw_prev);
    end
    if (w_stall && rst_n) begin
      chk1("w_hold_valid", wvalid, 1'b1);
      chkw("w_hold_data", wdata, w_prev_data);
      chk1("w_hold_last", wlast, w_prev_last);
    end
    if (b_fire) begin bvalid = 1'b0; b_fire = 1'b0; end
    awready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    wready  = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (!bvalid && bq.size() > 0 && !b_hold && (!rdy_rand || $urandom_range(0, 1) == 1)) begin
      bvalid = 1'b1;
      bid    = TB_ID;
      bresp  = (bq[0] == err_burst) ? 2'b10 : 2'b00;
    end
    if (rst_n) begin
      if (awvalid) awv_seen++;
      if (wvalid && wready) begin
        k  = w_beats / m_beats;
        chk1("w_after_aw", aw_done > k, 1'b1);
        ea = m_base + 64'(w_beats) * 64'd64;
        chkw("wdata", wdata, {16{ea[31:0]}});
        chk("wstrb", wstrb, 64'hFFFF_FFFF_FFFF_FFFF);
        chk1("wlast", wlast, (w_beats % m_beats) == (m_beats - 1));
        if ((w_beats % m_beats) == (m_beats - 1)) bq.push_back(k);
        w_beats++;
      end
      if (awvalid && awready) begin
        chk("awaddr", awaddr, m_base + 64'(aw_done) * 64'(m_beats) * 64'd64);
        chk("aw_fields", {32'd0, awid, awlen, 5'd0, awsize},
            {32'd0, TB_ID, 8'(m_beats - 1), 5'd0, 3'b110});
        chk1("aw_limit", (aw_done < m_nb) && ((aw_done - b_done) < MAXO), 1'b1);
        aw_done++;
      end
      if (bvalid && bready && bq.size() > 0) begin
        b_fire = 1'b1;
        b_done++;
        void'(bq.pop_front());
      end
    end
    aw_stall = rst_n && awvalid && !awready;
    aw_prev  = awaddr;
    w_stall  = rst_n && wvalid && !wready;
    w_prev_data = wdata;
    w_prev_last = wlast;
  endtask

  task automatic launch(input logic [63:0] base, input logic [15:0] nb, input logic [7:0] len);
    reset_model();
    m_base = base; m_nb = int'(nb); m_beats = int'(len) + 1;
    base_addr = base; num_bursts = nb; burst_len = len; start = 1'b1;
    tick();
    start = 1'b0;
    run_start = ncyc;
    chk1("busy_after_start", busy, 1'b1);
    chk1("err_cleared", err, 1'b0);
    chk("cycles_cleared", 64'(cycles), 64'd0);
  endtask

  task automatic finish_run(input logic exp_err);
    while (!done && (ncyc - run_start) < 8000) tick();
    chk1("done_seen", done, 1'b1);
    chk("cycles", 64'(cycles), 64'(ncyc - run_start));
    chk1("err_at_done", err, exp_err);
    chk("aw_count", 64'(aw_done), 64'(m_nb));
    chk("beat_count", 64'(w_beats), 64'(m_nb * m_beats));
    chk("b_count", 64'(b_done), 64'(m_nb));
    tick();
    chk1("done_one_cycle", done, 1'b0);
    chk1("busy_low_after", busy, 1'b0);
  endtask

  logic [31:0] saved_cycles;
  logic [63:0] rbase;
  logic [15:0] rnb;
  logic [7:0]  rlen;

  initial begin
    rst_n = 1'b0; start = 1'b0; base_addr = 64'd0; num_bursts = 16'd0; burst_len = 8'd0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = 16'd0; bresp = 2'b00;
    rdy_rand = 1'b0; b_hold = 1'b0; err_burst = -1; ncyc = 0; run_start = 0;
    m_base = 64'd0; m_nb = 0; m_beats = 1;
    reset_model();
    repeat (3) tick();
    chk1("rst_awvalid", awvalid, 1'b0);
    chk1("rst_wvalid", wvalid, 1'b0);
    chk1("rst_wlast", wlast, 1'b0);
    chk1("rst_bready", bready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk("rst_cycles", 64'(cycles), 64'd0);
    chk("rst_awaddr", awaddr, 64'd0);
    chkw("rst_wdata", wdata, 512'd0);
    rst_n = 1'b1;
    tick();

    // Two bursts of four beats with an always-ready slave.
    launch(64'h1000, 16'd2, 8'd3);
    finish_run(1'b0);

    // Responses withheld: issue must stop at the outstanding limit.
    b_hold = 1'b1;
    launch(64'h2_0000, 16'd8, 8'd1);
    repeat (40) tick();
    chk("aw_held_at_max", 64'(aw_done), 64'd4);
    chk1("awvalid_low_at_max", awvalid, 1'b0);
    chk("w_beats_at_max", 64'(w_beats), 64'd8);
    b_hold = 1'b0;
    while (aw_done < 5 && (ncyc - run_start) < 200) tick();
    chk("fifth_aw", 64'(aw_done), 64'd5);
    finish_run(1'b0);

    // Random back-pressure, including an address that wraps past 2^64.
    rdy_rand = 1'b1;
    for (int r = 0; r < 4; r++) begin
      rbase = {$urandom(), $urandom()};
      rnb   = 16'($urandom_range(2, 6));
      rlen  = 8'($urandom_range(0, 15));
      if (r == 2) begin rnb = 16'd2; rlen = 8'd255; end
      if (r == 3) rbase = 64'hFFFF_FFFF_FFFF_FF00;
      launch(rbase, rnb, rlen);
      finish_run(1'b0);
    end

    // Error response on the middle burst; a start during the run is ignored.
    err_burst = 1;
    launch(64'h8000, 16'd3, 8'd2);
    repeat (4) tick();
    chk1("busy_before_ignored_start", busy, 1'b1);
    start = 1'b1; base_addr = 64'hDEAD_0000; num_bursts = 16'd9; burst_len = 8'd0;
    tick();
    start = 1'b0;
    finish_run(1'b1);
    saved_cycles = cycles;
    repeat (3) tick();
    chk1("err_sticky", err, 1'b1);
    chk("cycles_hold", 64'(cycles), 64'(saved_cycles));
    err_burst = -1;

    // Empty run: no address traffic and a single RUN cycle.
    launch(64'h4000, 16'd0, 8'd5);
    finish_run(1'b0);
    chk("zero_cycles", 64'(cycles), 64'd1);
    chk("zero_no_awvalid", 64'(awv_seen), 64'd0);

    // Reset in the middle of a run abandons it immediately.
    launch(64'h9000, 16'd4, 8'd7);
    while (w_beats < 3 && (ncyc - run_start) < 500) tick();
    chk1("midrun_reached", w_beats >= 3, 1'b1);
    rst_n = 1'b0;
    tick();
    chk1("mid_rst_awvalid", awvalid, 1'b0);
    chk1("mid_rst_wvalid", wvalid, 1'b0);
    chk1("mid_rst_wlast", wlast, 1'b0);
    chk1("mid_rst_bready", bready, 1'b0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_done", done, 1'b0);
    chk("mid_rst_cycles", 64'(cycles), 64'd0);
    chk("mid_rst_awaddr", awaddr, 64'd0);
    rst_n = 1'b1;
    reset_model();
    tick();
    launch(64'hA000, 16'd1, 8'd0);
    finish_run(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
